// File: rtl/addsub_arb_pkg.sv
// Shared types and the round-robin pick function used by addsub_arbiter.
package addsub_arb_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int MAX_NREQ  = 8;
  localparam int MAX_IDW   = 3;

  typedef enum logic { OP_ADD = 1'b0, OP_SUB = 1'b1 } op_e;
  typedef enum logic { ST_EMPTY = 1'b0, ST_FULL = 1'b1 } state_e;

  // First set bit of valid at or after ptr, wrapping at nreq; returns ptr when nothing is set.
  function automatic logic [MAX_IDW-1:0] rr_pick(input logic [MAX_NREQ-1:0] valid,
                                                 input logic [MAX_IDW-1:0]  ptr,
                                                 input int unsigned         nreq);
    logic [MAX_IDW-1:0] pick;
    logic               found;
    int unsigned        idx;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_NREQ; k++) begin
      idx = (32'(ptr) + k) % nreq;
      if (!found && (k < nreq) && valid[idx[MAX_IDW-1:0]]) begin
        pick  = idx[MAX_IDW-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/addsub_unit.sv
// Combinational WIDTH-bit add/subtract with zero flag.
// With ADDSUB_ARB_OVF_EN defined it also reports add carry-out / subtract borrow.
module addsub_unit
  import addsub_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             do_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
`ifdef ADDSUB_ARB_OVF_EN
  output logic             ovf,
`endif
  output logic             is_zero
);

  op_e op;

`ifdef ADDSUB_ARB_OVF_EN
  logic [WIDTH:0] ext;

  // The extra top bit of the widened result is the carry (add) or borrow (sub).
  always_comb begin
    op = op_e'(do_sub);
    case (op)
      OP_SUB:  ext = {1'b0, a} - {1'b0, b};
      default: ext = {1'b0, a} + {1'b0, b};
    endcase
    out     = ext[WIDTH-1:0];
    ovf     = ext[WIDTH];
    is_zero = (ext[WIDTH-1:0] == '0);
  end
`else
  always_comb begin
    op = op_e'(do_sub);
    case (op)
      OP_SUB:  out = a - b;
      default: out = a + b;
    endcase
    is_zero = (out == '0);
  end
`endif

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one add/sub unit among NREQ requesters, with a one-entry
// valid/ready result register. Define ADDSUB_ARB_OVF_EN to add the registered rsp_ovf output.
module addsub_arbiter
  import addsub_arb_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = DEF_WIDTH,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0]       req_do_sub,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_out,
  output logic                  rsp_is_zero,
`ifdef ADDSUB_ARB_OVF_EN
  output logic                  rsp_ovf,
`endif
  output logic [IDW-1:0]        rsp_id
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rsp_out_q, rsp_out_d;
  logic             rsp_is_zero_q, rsp_is_zero_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
`ifdef ADDSUB_ARB_OVF_EN
  logic             rsp_ovf_q, rsp_ovf_d;
  logic             unit_ovf;
`endif

  logic [MAX_NREQ-1:0] valid_ext;
  logic [IDW-1:0]      gnt_idx;
  logic                any_valid;
  logic                accept_en;
  logic                xfer;
  logic                gnt_sub;
  logic [WIDTH-1:0]    gnt_a, gnt_b;
  logic [WIDTH-1:0]    unit_out;
  logic                unit_zero;

  // Grant selection and operand steering; nothing is accepted while reset is asserted.
  always_comb begin
    valid_ext           = '0;
    valid_ext[NREQ-1:0] = req_valid;
    gnt_idx             = IDW'(rr_pick(valid_ext, MAX_IDW'(ptr_q), NREQ));
    any_valid           = |req_valid;
    accept_en           = (state_q == ST_EMPTY) || rsp_ready;
    xfer                = aresetn && any_valid && accept_en;
    req_ready           = '0;
    req_ready[gnt_idx]  = xfer;
    gnt_sub             = req_do_sub[gnt_idx];
    gnt_a               = req_a[gnt_idx*WIDTH +: WIDTH];
    gnt_b               = req_b[gnt_idx*WIDTH +: WIDTH];
  end

  addsub_unit #(
    .WIDTH   (WIDTH)
  ) u_unit (
    .do_sub  (gnt_sub),
    .a       (gnt_a),
    .b       (gnt_b),
    .out     (unit_out),
`ifdef ADDSUB_ARB_OVF_EN
    .ovf     (unit_ovf),
`endif
    .is_zero (unit_zero)
  );

  // A transfer always refills the register; otherwise a consumed result just empties it.
  always_comb begin
    state_d       = state_q;
    rsp_out_d     = rsp_out_q;
    rsp_is_zero_d = rsp_is_zero_q;
    rsp_id_d      = rsp_id_q;
    ptr_d         = ptr_q;
`ifdef ADDSUB_ARB_OVF_EN
    rsp_ovf_d     = rsp_ovf_q;
`endif
    if (xfer) begin
      state_d       = ST_FULL;
      rsp_out_d     = unit_out;
      rsp_is_zero_d = unit_zero;
      rsp_id_d      = gnt_idx;
      ptr_d         = (32'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
`ifdef ADDSUB_ARB_OVF_EN
      rsp_ovf_d     = unit_ovf;
`endif
    end else if (rsp_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= ST_EMPTY;
      rsp_out_q     <= '0;
      rsp_is_zero_q <= 1'b0;
      rsp_id_q      <= '0;
      ptr_q         <= '0;
`ifdef ADDSUB_ARB_OVF_EN
      rsp_ovf_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      rsp_out_q     <= rsp_out_d;
      rsp_is_zero_q <= rsp_is_zero_d;
      rsp_id_q      <= rsp_id_d;
      ptr_q         <= ptr_d;
`ifdef ADDSUB_ARB_OVF_EN
      rsp_ovf_q     <= rsp_ovf_d;
`endif
    end
  end

  assign rsp_valid   = (state_q == ST_FULL);
  assign rsp_out     = rsp_out_q;
  assign rsp_is_zero = rsp_is_zero_q;
  assign rsp_id      = rsp_id_q;
`ifdef ADDSUB_ARB_OVF_EN
  assign rsp_ovf     = rsp_ovf_q;
`endif

endmodule

// File: tb/tb_addsub_arbiter.sv
// Bench for addsub_arbiter: cycle model plus per-requester scoreboard, directed vectors with
// literal expectations, then a constrained-random phase. Honours ADDSUB_ARB_OVF_EN.
module tb_addsub_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int LITN  = 4096;

  typedef struct packed {
    logic [7:0] out;
    logic       zero;
    logic       ovf;
  } res_t;

  logic                  clk = 1'b0;
  logic                  aresetn = 1'b0;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_do_sub;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_out;
  logic                  rsp_is_zero;
  logic [1:0]            rsp_id;
`ifdef ADDSUB_ARB_OVF_EN
  logic                  rsp_ovf;
`endif

  addsub_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk         (clk),
    .aresetn     (aresetn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_do_sub  (req_do_sub),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_out     (rsp_out),
    .rsp_is_zero (rsp_is_zero),
`ifdef ADDSUB_ARB_OVF_EN
    .rsp_ovf     (rsp_ovf),
`endif
    .rsp_id      (rsp_id)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   rst_cnt = 0;
  int   end_cyc = -1;
  logic lit_v   [LITN];
  res_t lit_res [LITN];
  int   lit_id  [LITN];
  res_t sbq [NREQ][$];

  always @(negedge aresetn) rst_cnt++;

  // Reference arithmetic: unsigned integers, wrap by modulo.
  function automatic res_t ref_op(input logic sub, input logic [7:0] a, input logic [7:0] b);
    int unsigned va, vb, r;
    res_t        res;
    va       = a;
    vb       = b;
    r        = sub ? (va + 256 - vb) : (va + vb);
    res.out  = 8'(r % 256);
    res.zero = (r % 256) == 0;
    res.ovf  = sub ? (va < vb) : (r > 255);
    return res;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Compare process: checks on every falling edge, advances the model on every rising edge.
  initial begin : compare
    logic            m_full, n_full;
    res_t            m_res, n_res, r;
    int              m_id, n_id, m_ptr, n_ptr, g, rst_seen, tot, id;
    logic            accept;
    logic [NREQ-1:0] exp_ready;
    m_full = 0; m_res = '0; m_id = 0; m_ptr = 0; rst_seen = 0;
    forever begin
      @(negedge clk);
      if (rst_cnt != rst_seen) begin
        rst_seen = rst_cnt;
        m_full = 0; m_res = '0; m_id = 0; m_ptr = 0;
        for (int i = 0; i < NREQ; i++) sbq[i].delete();
        chk("reset_valid", 32'(rsp_valid), 0);
        chk("reset_out", 32'(rsp_out), 0);
        chk("reset_zero", 32'(rsp_is_zero), 0);
        chk("reset_id", 32'(rsp_id), 0);
      end
      n_full = m_full; n_res = m_res; n_id = m_id; n_ptr = m_ptr;
      if (!aresetn) begin
        m_full = 0; m_res = '0; m_id = 0; m_ptr = 0;
        n_full = 0; n_res = '0; n_id = 0; n_ptr = 0;
        for (int i = 0; i < NREQ; i++) sbq[i].delete();
        chk("ready_in_reset", 32'(req_ready), 0);
        chk("valid_in_reset", 32'(rsp_valid), 0);
      end else begin
        chk("rsp_valid", 32'(rsp_valid), 32'(m_full));
        chk("rsp_out", 32'(rsp_out), 32'(m_res.out));
        chk("rsp_is_zero", 32'(rsp_is_zero), 32'(m_res.zero));
        chk("rsp_id", 32'(rsp_id), m_id);
`ifdef ADDSUB_ARB_OVF_EN
        chk("rsp_ovf", 32'(rsp_ovf), 32'(m_res.ovf));
`endif
        if (cyc < LITN && lit_v[cyc]) begin
          chk("lit_valid", 32'(rsp_valid), 1);
          chk("lit_out", 32'(rsp_out), 32'(lit_res[cyc].out));
          chk("lit_zero", 32'(rsp_is_zero), 32'(lit_res[cyc].zero));
          chk("lit_id", 32'(rsp_id), lit_id[cyc]);
`ifdef ADDSUB_ARB_OVF_EN
          chk("lit_ovf", 32'(rsp_ovf), 32'(lit_res[cyc].ovf));
`endif
        end
        accept = !m_full || rsp_ready;
        g = -1;
        for (int k = 0; k < NREQ; k++)
          if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
        exp_ready = '0;
        if (g >= 0 && accept) exp_ready[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        // Scoreboard driven by the DUT's own handshakes: pop before push for same-edge refill.
        if (rsp_valid && rsp_ready) begin
          id = int'(rsp_id);
          chk("sb_nonempty", 32'(sbq[id].size() != 0), 1);
          if (sbq[id].size() != 0) begin
            r = sbq[id].pop_front();
            chk("sb_out", 32'(rsp_out), 32'(r.out));
            chk("sb_zero", 32'(rsp_is_zero), 32'(r.zero));
          end
        end
        for (int i = 0; i < NREQ; i++)
          if (req_valid[i] && req_ready[i])
            sbq[i].push_back(ref_op(req_do_sub[i], req_a[i*WIDTH +: WIDTH], req_b[i*WIDTH +: WIDTH]));
        if (g >= 0 && accept) begin
          n_full = 1;
          n_res  = ref_op(req_do_sub[g], req_a[g*WIDTH +: WIDTH], req_b[g*WIDTH +: WIDTH]);
          n_id   = g;
          n_ptr  = (g + 1) % NREQ;
        end else if (rsp_ready) begin
          n_full = 0;
        end
      end
      if (cyc == end_cyc) begin
        tot = 0;
        for (int i = 0; i < NREQ; i++) tot += sbq[i].size();
        chk("sb_drained", 32'(tot), 0);
      end
      @(posedge clk);
      m_full = n_full; m_res = n_res; m_id = n_id; m_ptr = n_ptr;
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic sub,
                         input logic [7:0] a, input logic [7:0] b);
    req_valid[i]              = v;
    req_do_sub[i]             = sub;
    req_a[i*WIDTH +: WIDTH]   = a;
    req_b[i*WIDTH +: WIDTH]   = b;
  endtask

  // Hand-computed expectation for the falling edge d cycles from now.
  task automatic expect_lit(input int d, input logic [7:0] out, input logic zero,
                            input logic ovf, input int id);
    lit_v[cyc + d]       = 1'b1;
    lit_res[cyc + d].out  = out;
    lit_res[cyc + d].zero = zero;
    lit_res[cyc + d].ovf  = ovf;
    lit_id[cyc + d]      = id;
  endtask

  initial begin : stimulus
    logic [NREQ-1:0] taken;
    logic [7:0]      ra, rb;
    for (int i = 0; i < LITN; i++) begin
      lit_v[i] = 1'b0; lit_res[i] = '0; lit_id[i] = 0;
    end
    req_valid = '0; req_do_sub = '0; req_a = '0; req_b = '0;
    rsp_ready = 1'b1;
    repeat (3) tick();
    aresetn = 1'b1;
    tick();

    // Reset while FULL, then requesters 1 and 3 race from ptr=0.
    set_req(1, 1, 0, 8'h12, 8'h34);
    expect_lit(1, 8'h46, 0, 0, 1);
    tick();
    set_req(1, 0, 0, 8'h00, 8'h00);
    rsp_ready = 1'b0;
    tick();
    set_req(1, 1, 1, 8'h50, 8'h05);
    set_req(3, 1, 0, 8'h70, 8'h07);
    rsp_ready = 1'b1;
    expect_lit(1, 8'h4B, 0, 0, 1);
    expect_lit(2, 8'h77, 0, 0, 3);
    #2 aresetn = 1'b0;
    #1 aresetn = 1'b1;
    tick();
    set_req(1, 0, 0, 8'h00, 8'h00);
    tick();
    set_req(3, 0, 0, 8'h00, 8'h00);
    tick();

    // Single requester 0: add then subtract.
    set_req(0, 1, 0, 8'hAA, 8'hBB);
    expect_lit(1, 8'h65, 0, 1, 0);
    tick();
    set_req(0, 1, 1, 8'hAA, 8'hBB);
    expect_lit(1, 8'hEF, 0, 1, 0);
    tick();
    set_req(0, 0, 0, 8'h00, 8'h00);
    tick();

    // Zero-flag and wrap cases on requester 3 (leaves ptr at 0).
    set_req(3, 1, 1, 8'h03, 8'h03);
    expect_lit(1, 8'h00, 1, 0, 3);
    tick();
    set_req(3, 1, 0, 8'hFD, 8'h03);
    expect_lit(1, 8'h00, 1, 1, 3);
    tick();
    set_req(3, 1, 1, 8'h03, 8'h04);
    expect_lit(1, 8'hFF, 0, 1, 3);
    tick();
    set_req(3, 0, 0, 8'h00, 8'h00);
    tick();

    // All four valid: ids 0,1,2,3,0,1,2,3 back to back.
    for (int i = 0; i < NREQ; i++) set_req(i, 1, 0, 8'(8'h10 * i + 1), 8'(i));
    expect_lit(1, 8'h01, 0, 0, 0); expect_lit(2, 8'h12, 0, 0, 1);
    expect_lit(3, 8'h23, 0, 0, 2); expect_lit(4, 8'h34, 0, 0, 3);
    expect_lit(5, 8'h01, 0, 0, 0); expect_lit(6, 8'h12, 0, 0, 1);
    expect_lit(7, 8'h23, 0, 0, 2); expect_lit(8, 8'h34, 0, 0, 3);
    repeat (8) tick();

    // Backpressure for five cycles while FULL, then resume with requester 0 next.
    rsp_ready = 1'b0;
    for (int d = 0; d < 5; d++) expect_lit(d, 8'h34, 0, 0, 3);
    repeat (4) tick();
    rsp_ready = 1'b1;
    expect_lit(1, 8'h01, 0, 0, 0);
    expect_lit(2, 8'h12, 0, 0, 1);
    repeat (2) tick();
    for (int i = 0; i < NREQ; i++) set_req(i, 0, 0, 8'h00, 8'h00);
    repeat (2) tick();

    // Random phase: a requester only changes its request once it is idle or was accepted.
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      taken = req_valid & req_ready;
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || taken[i]) begin
          ra = 8'($urandom);
          rb = ($urandom_range(0, 7) == 0) ? ra : 8'($urandom);
          set_req(i, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), ra, rb);
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    taken = req_valid & req_ready;
    tick();
    for (int i = 0; i < NREQ; i++) if (taken[i]) set_req(i, 0, 0, 8'h00, 8'h00);
    rsp_ready = 1'b1;
    // Any still-pending request drains one per cycle; after that everything is idle.
    repeat (NREQ + 1) begin
      @(negedge clk);
      taken = req_valid & req_ready;
      tick();
      for (int i = 0; i < NREQ; i++) if (taken[i]) set_req(i, 0, 0, 8'h00, 8'h00);
    end
    tick();
    end_cyc = cyc;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
- Shares one 8-bit add/subtract datapath (a+b or a-b, plus zero flag) between NREQ requesters.
- Each cycle, a round-robin arbiter grants at most one valid request. The granted operands drive the shared unit, and the result is captured into a one-entry output register with a valid/ready handshake.
- Sits between several ALU clients and a single result consumer; the result carries the requester id.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, operand/result width in bits
- IDW, $clog2(NREQ), requester id width (derived, not overridden)

Ports:
- clk  in  1  clock, all state on posedge
- aresetn  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle
- req_do_sub  in  NREQ  per-requester op: 0 = add, 1 = subtract
- req_a  in  NREQ*WIDTH  operand a; requester i occupies bits [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  operand b; same packing as req_a
- rsp_valid  out  1  result register holds an unconsumed result
- rsp_ready  in  1  consumer accepts the result
- rsp_out  out  WIDTH  result, modulo 2^WIDTH
- rsp_is_zero  out  1  rsp_out == 0
- rsp_id  out  IDW  index of the requester that produced the result

Behaviour:
- Reset (aresetn low, async) clears rsp_valid, rsp_out, rsp_is_zero, rsp_id and the round-robin pointer ptr to 0. Any in-flight result is discarded. req_ready is 0 while in reset.
- Two states, encoded by rsp_valid:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
- accept_en = !rsp_valid || rsp_ready. A pipelined refill in the same cycle as the drain is allowed.
- Arbitration (combinational):
  - Scan req_valid starting at index ptr, ascending with wrap-around.
  - The first set bit wins (gnt_idx).
  - req_ready[gnt_idx] = accept_en; all other req_ready bits are 0.
  - Requesters must not make req_valid depend on req_ready.
- Transfer: occurs when req_valid[g] && req_ready[g]. On that posedge:
  - rsp_out <= do_sub ? a-b : a+b (WIDTH bits; carry/borrow discarded)
  - rsp_is_zero <= (result == 0)
  - rsp_id <= g
  - rsp_valid <= 1
  - ptr <= (g+1) mod NREQ
- Latency: exactly 1 cycle from the accepting edge to rsp_valid=1. Throughput is 1 op/cycle while rsp_ready=1.
- FULL with rsp_ready=0: the output is held stable and all req_ready are 0. A stalled requester keeps its request valid with stable operands.
- FULL with rsp_ready=1 and no request pending: rsp_valid <= 0; the data outputs hold their last values.
- No request valid: ptr unchanged.
- Simultaneous requests: the requester nearest ptr wins. Starvation-free; any requester waits at most NREQ-1 grants.
- Wrap examples: 0xFD+0x03=0x00 (zero=1); 0x03-0x04=0xFF (zero=0).

Optional Feature:
- Macro: ADDSUB_ARB_OVF_EN.
- When defined: adds port rsp_ovf (out, 1), registered alongside rsp_out.
  - add: carry-out of the unsigned add.
  - sub: borrow (a < b unsigned).
  - Reset value 0.
- When undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Package addsub_arb_pkg:
  - localparam DEF_WIDTH=8
  - typedef op_e {OP_ADD=1'b0, OP_SUB=1'b1}
  - function rr_pick(valid, ptr) returning the granted index
- Sub-module addsub_unit: purely combinational (do_sub, a, b -> out, is_zero[, ovf]), instantiated once.
- The arbiter, pointer and output register live in addsub_arbiter.

Test Plan:
- Reset mid-FULL: capture a result, then pulse aresetn low between edges.
  - rsp_valid, rsp_out and rsp_is_zero go to 0 immediately.
  - After release, with requesters 1 and 3 valid, the first grant goes to 1 (ptr=0).
- Single requester 0, a=0xAA, b=0xBB, add then sub, rsp_ready=1.
  - Results 0x65 (zero=0) then 0xEF (zero=0), each 1 cycle after acceptance, rsp_id=0.
- Zero flag:
  - a=0x03, b=0x03 sub -> 0x00, zero=1.
  - a=0xFD, b=0x03 add -> 0x00, zero=1 (ovf=1 if enabled).
  - a=0x03, b=0x04 sub -> 0xFF, zero=0 (ovf=1 if enabled).
- All 4 requesters valid continuously, rsp_ready=1: rsp_id sequence is 0,1,2,3,0,…, one per cycle, with no gaps.
- Backpressure: rsp_ready=0 for 5 cycles while FULL.
  - rsp_* stable, all req_ready=0.
  - When rsp_ready rises, the next result appears the following cycle with no lost or duplicated ops.
- Random: 1000 cycles of random valid, operands, ops and rsp_ready.
  - Per-requester scoreboard matches a reference a±b mod 256 and the zero flag.
  - Every accepted op is returned exactly once, in per-requester order.
